// File: rtl/ex_unit.sv
// ex_unit: execute stage with operand forwarding and single-cycle logic,
// arithmetic and shift operations. A registered output stage sits behind a
// valid/ready handshake.
// Optional feature macro: EX_UNIT_MUL_EN. When it is defined, the unit adds an
// iterative shift-add multiplier and the BUSY state. When it is undefined,
// opcode 11 is a single-cycle op that returns 0.
module ex_unit #(
    parameter int WIDTH   = 16,
    parameter int NUM_FWD = 2,
    parameter int SELW    = $clog2(NUM_FWD + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               op,
    input  logic [WIDTH-1:0]         src_a,
    input  logic [WIDTH-1:0]         src_b,
    input  logic [WIDTH-1:0]         st_data,
    input  logic [SELW-1:0]          fwd_sel_a,
    input  logic [SELW-1:0]          fwd_sel_b,
    input  logic [SELW-1:0]          fwd_sel_c,
    input  logic [NUM_FWD*WIDTH-1:0] fwd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         alu_out,
    output logic [WIDTH-1:0]         st_wdata_out
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FULL} state_e;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_AND = 4'd1, OP_NOT = 4'd2, OP_PASS_A = 4'd3,
        OP_PASS_B = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
        OP_SUB = 4'd8, OP_OR = 4'd9, OP_XOR = 4'd10, OP_MUL = 4'd11
    } op_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] st_q, st_d;
    logic [WIDTH-1:0] op_a, op_b, op_c, result;
    logic             accept;

`ifdef EX_UNIT_MUL_EN
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] addend;
`endif

    // A select of 0, or a select beyond the last source, keeps the register value.
    function automatic logic [WIDTH-1:0] fwd_pick(
        input logic [SELW-1:0]          sel,
        input logic [WIDTH-1:0]         reg_val,
        input logic [NUM_FWD*WIDTH-1:0] fwd
    );
        logic [WIDTH-1:0] v;
        v = reg_val;
        for (int k = 1; k <= NUM_FWD; k++) begin
            if (int'(sel) == k) v = fwd[(k-1)*WIDTH +: WIDTH];
        end
        return v;
    endfunction

    assign op_a      = fwd_pick(fwd_sel_a, src_a, fwd_data);
    assign op_b      = fwd_pick(fwd_sel_b, src_b, fwd_data);
    assign op_c      = fwd_pick(fwd_sel_c, st_data, fwd_data);
    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_FULL) && out_ready);
    assign accept    = in_valid && in_ready;
    assign alu_out      = alu_q;
    assign st_wdata_out = st_q;

    // Single-cycle result. MUL and the unused opcodes fall through to 0.
    // NOTE: a combinational block assigns every output a default first, so no path infers a latch.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:    result = op_a + op_b;
            OP_AND:    result = op_a & op_b;
            OP_NOT:    result = ~op_a;
            OP_PASS_A: result = op_a;
            OP_PASS_B: result = op_b;
            OP_SLL:    result = op_a << op_b[SHW-1:0];
            OP_SRL:    result = op_a >> op_b[SHW-1:0];
            OP_SRA:    result = $signed(op_a) >>> op_b[SHW-1:0];
            OP_SUB:    result = op_a - op_b;
            OP_OR:     result = op_a | op_b;
            OP_XOR:    result = op_a ^ op_b;
            default:   result = '0;
        endcase
    end

    // Next state. The result registers load only on the edge that enters FULL.
    always_comb begin
        state_d = state_q;
        alu_d   = alu_q;
        st_d    = st_q;
`ifdef EX_UNIT_MUL_EN
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        pend_d   = pend_q;
        addend   = mplier_q[0] ? mcand_q : '0;
`endif
        case (state_q)
            ST_IDLE, ST_FULL: begin
                if (accept) begin
`ifdef EX_UNIT_MUL_EN
                    if (op == OP_MUL) begin
                        state_d  = ST_BUSY;
                        cnt_d    = SHW'(WIDTH - 1);
                        mcand_d  = op_a;
                        mplier_d = op_b;
                        prod_d   = '0;
                        pend_d   = op_c;
                    end else
`endif
                    begin
                        state_d = ST_FULL;
                        alu_d   = result;
                        st_d    = op_c;
                    end
                end else if ((state_q == ST_FULL) && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef EX_UNIT_MUL_EN
            ST_BUSY: begin
                prod_d   = prod_q + addend;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d = ST_FULL;
                    cnt_d   = '0;
                    alu_d   = prod_q + addend;
                    st_d    = pend_q;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            alu_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            st_q    <= st_d;
        end
    end

`ifdef EX_UNIT_MUL_EN
    // Multiplier iteration registers. Reset clears them and aborts a multiply in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            pend_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            pend_q   <= pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit: randomized and directed bench for ex_unit. It checks every cycle
// against a transaction-level reference model.
module tb_ex_unit;
    localparam int W   = 16;
    localparam int NF  = 2;
    localparam int SW  = $clog2(NF + 1);
`ifdef EX_UNIT_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n, in_valid, in_ready, out_valid, out_ready;
    logic [3:0]      op;
    logic [W-1:0]    src_a, src_b, st_data, alu_out, st_wdata_out;
    logic [SW-1:0]   fwd_sel_a, fwd_sel_b, fwd_sel_c;
    logic [NF*W-1:0] fwd_data;
    logic [W-1:0]    fwd_v [NF];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: the held result, and cycles left on a pending multiply.
    bit           m_valid;
    logic [W-1:0] m_alu, m_st, m_pres, m_pst;
    int           m_busy;

    always #5 clk = ~clk;

    always_comb begin
        fwd_data = '0;
        for (int k = 0; k < NF; k++) fwd_data[k*W +: W] = fwd_v[k];
    end

    ex_unit #(.WIDTH(W), .NUM_FWD(NF)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src_a(src_a), .src_b(src_b), .st_data(st_data),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .fwd_sel_c(fwd_sel_c),
        .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
        .alu_out(alu_out), .st_wdata_out(st_wdata_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input int sel, input logic [W-1:0] regv);
        if (sel >= 1 && sel <= NF) return fwd_v[sel-1];
        return regv;
    endfunction

    // Result computed with plain integer arithmetic, then reduced modulo 2^W.
    function automatic logic [W-1:0] ref_alu(input int opc, input int a, input int b);
        int     sh;
        int     sa;
        longint r;
        sh = b % W;
        sa = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        case (opc)
            0:  r = a + b;
            1:  r = a & b;
            2:  r = (1 << W) - 1 - a;
            3:  r = a;
            4:  r = b;
            5:  r = longint'(a) * (longint'(1) << sh);
            6:  r = a / (1 << sh);
            7:  r = sa >>> sh;
            8:  r = a - b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = MUL_EN ? longint'(a) * longint'(b) : 0;
            default: r = 0;
        endcase
        return r[W-1:0];
    endfunction

    function automatic bit exp_in_ready();
        return (m_busy == 0) && (!m_valid || out_ready);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit           acc;
        logic [W-1:0] a, b, c;
        acc = in_valid && exp_in_ready();
        if (!reset_n) begin
            m_valid = 0; m_alu = '0; m_st = '0; m_busy = 0;
            return;
        end
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_valid = 1; m_alu = m_pres; m_st = m_pst; end
            return;
        end
        if (m_valid && out_ready) m_valid = 0;
        if (acc) begin
            a = pick(int'(fwd_sel_a), src_a);
            b = pick(int'(fwd_sel_b), src_b);
            c = pick(int'(fwd_sel_c), st_data);
            if (op == 4'd11 && MUL_EN) begin
                m_busy = W; m_pres = ref_alu(int'(op), int'(a), int'(b)); m_pst = c;
            end else begin
                m_valid = 1; m_alu = ref_alu(int'(op), int'(a), int'(b)); m_st = c;
            end
        end
    endtask

    // One cycle: check in_ready combinationally, clock, then check registered outputs.
    task automatic tick();
        #1;
        check("in_ready", in_ready, exp_in_ready());
        model_edge();
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_valid);
        check("alu_out", alu_out, m_alu);
        check("st_wdata_out", st_wdata_out, m_st);
    endtask

    task automatic set_op(input int opc, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] c);
        in_valid = 1'b1; op = 4'(opc); src_a = a; src_b = b; st_data = c;
        fwd_sel_a = '0; fwd_sel_b = '0; fwd_sel_c = '0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
    endtask

    int n;
    int opc;

    initial begin
        m_valid = 0; m_alu = '0; m_st = '0; m_busy = 0; m_pres = '0; m_pst = '0;
        reset_n = 1'b0; out_ready = 1'b1;
        set_op(0, 16'h1111, 16'h2222, 16'h3333);
        fwd_v[0] = 16'h0; fwd_v[1] = 16'h0;

        // Reset held for two edges while an op is offered.
        @(posedge clk); #1;
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_alu_out", alu_out, 0);
        check("rst_st_wdata", st_wdata_out, 0);
        reset_n = 1'b1; in_valid = 1'b0;
        #1 check("rst_in_ready", in_ready, 1);

        // Forwarding: a from source 2, b from source 1, store data select out of range.
        set_op(0, 16'h0001, 16'h7777, 16'hBEEF);
        fwd_v[1] = 16'h0200; fwd_v[0] = 16'h0030;
        fwd_sel_a = 2'd2; fwd_sel_b = 2'd1; fwd_sel_c = 2'd3;
        tick();
        check("fwd_alu", alu_out, 16'h0230);
        check("fwd_st", st_wdata_out, 16'hBEEF);

        // Shifts by one (b = 0x0011, low four bits = 1).
        set_op(5, 16'h8001, 16'h0011, 16'h0); tick(); check("sll", alu_out, 16'h0002);
        set_op(6, 16'h8001, 16'h0011, 16'h0); tick(); check("srl", alu_out, 16'h4000);
        set_op(7, 16'h8001, 16'h0011, 16'h0); tick(); check("sra", alu_out, 16'hC000);
        drain();

        // Multiply: latency and result.
        set_op(11, 16'h0123, 16'h0045, 16'h5A5A);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin tick(); n++; end
        check("mul_latency", n, MUL_EN ? W : 0);
        check("mul_alu", alu_out, MUL_EN ? 16'h4E6F : 16'h0000);
        check("mul_st", st_wdata_out, 16'h5A5A);
        drain();

        // Back-pressure: the first result is held while the second op waits.
        out_ready = 1'b0;
        set_op(0, 16'h0010, 16'h0020, 16'h0A0A);
        tick();
        set_op(0, 16'h0100, 16'h0001, 16'h0B0B);
        repeat (3) begin
            tick();
            check("bp_hold", alu_out, 16'h0030);
            check("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_second", alu_out, 16'h0101);
        check("bp_second_st", st_wdata_out, 16'h0B0B);
        drain();

        // Reset in the middle of a multiply.
        set_op(11, 16'h0007, 16'h0009, 16'h0);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        repeat (20) begin tick(); check("abort_no_valid", out_valid, 0); end
        set_op(0, 16'h0002, 16'h0003, 16'h0);
        tick();
        check("post_abort_add", alu_out, 16'h0005);
        check("post_abort_valid", out_valid, 1);

        // Randomized traffic with back-pressure, forwarding and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            reset_n   = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            opc       = $urandom_range(0, 15);
            op        = 4'(opc);
            src_a     = W'($urandom);
            src_b     = W'($urandom);
            st_data   = W'($urandom);
            fwd_v[0]  = W'($urandom);
            fwd_v[1]  = W'($urandom);
            fwd_sel_a = SW'($urandom_range(0, 3));
            fwd_sel_b = SW'($urandom_range(0, 3));
            fwd_sel_c = SW'($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ex_unit.md
# ex_unit

Parametrised execute-stage unit: selects ALU operands and store data from the register-file values or from any of `NUM_FWD` forwarding sources, then executes single-cycle logic/arith/shift ops or an iterative multi-cycle multiply. Results are held in a registered output stage with a valid/ready handshake, so the unit can stall the pipeline for multi-cycle ops and for downstream back-pressure. It sits between the decode/register-read stage and the MEM stage.

## Interface
- `WIDTH`, 16, datapath width in bits (≥4, power of two).
- `NUM_FWD`, 2, number of forwarding sources; index 0 is the nearest stage (EX/MEM).
- `SELW`, `$clog2(NUM_FWD+1)`, width of each forward select (derived, not overridden).

- `clk`  in  1  clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream has an op.
- `in_ready`  out  1  unit accepts op this cycle.
- `op`  in  4  opcode (see Operation).
- `src_a`, `src_b`, `st_data`  in  WIDTH each  register-file operands and store data.
- `fwd_sel_a`, `fwd_sel_b`, `fwd_sel_c`  in  SELW each  0 = register value, k = `fwd_data[k-1]`.
- `fwd_data`  in  NUM_FWD*WIDTH  flattened forward values, source k at bits [k*WIDTH +: WIDTH].
- `out_valid`  out  1  result held.
- `out_ready`  in  1  downstream takes result.
- `alu_out`  out  WIDTH  result.
- `st_wdata_out`  out  WIDTH  forwarded store data, aligned with `alu_out`.

## Operation
- Opcodes: 0 ADD, 1 AND, 2 NOT (~a), 3 PASS_A, 4 PASS_B, 5 SLL, 6 SRL, 7 SRA, 8 SUB (a−b), 9 OR, 10 XOR, 11 MUL; 12–15 produce 0, single-cycle.
- Arithmetic modulo 2^WIDTH; no flags. Shift amount = b[$clog2(WIDTH)-1:0]; SRA sign-fills. MUL returns low WIDTH bits of a×b (unsigned; identical for signed low half).
- Forward select value > NUM_FWD selects the register value.
- Operands and store data (post-forward) are captured only in the accept cycle (`in_valid && in_ready`); forwarding inputs are ignored otherwise.
- FSM states: IDLE (empty), BUSY (multiply iterating), FULL (`out_valid`=1).
  - IDLE, accept single-cycle op → FULL with result.
  - IDLE, accept MUL → BUSY, counter = WIDTH−1, multiplicand/multiplier/partial product loaded.
  - BUSY: one shift-add step per cycle; counter 0 → FULL.
  - FULL, `out_ready`=0 → FULL, outputs stable.
  - FULL, `out_ready`=1: accept single-cycle → FULL (new result); accept MUL → BUSY; no input → IDLE.
- `in_ready` = (state==IDLE) | (state==FULL & `out_ready`); 0 in BUSY.

## Timing
- Reset (`reset_n`=0 at edge): state IDLE, `out_valid`=0, `alu_out`=0, `st_wdata_out`=0, counter=0; `in_ready`=1 after reset.
- Reset mid-multiply aborts it; no result emitted.
- Single-cycle latency: accepted at edge k → `out_valid`=1 after edge k.
- MUL latency: accepted at edge k → `out_valid`=1 after edge k+WIDTH; `in_ready`=0 for cycles k+1..k+WIDTH.
- Full throughput (one single-cycle op per clock) with `out_ready` held 1.
- `in_ready` depends combinationally on `out_ready`; no other input→output combinational path.
- `alu_out`/`st_wdata_out` change only on the edge that loads FULL.

## Configuration
- `EX_UNIT_MUL_EN`: defined → MUL iterative path and BUSY state present as above. Undefined → no multiplier hardware, BUSY unreachable, opcode 11 behaves as 12–15 (single-cycle, result 0).

## Test plan
- Reset: hold `reset_n`=0 two cycles with `in_valid`=1 → `out_valid`=0, `alu_out`=0, `st_wdata_out`=0; `in_ready`=1 after release.
- Forwarding: `op`=ADD, `src_a`=0x0001, `fwd_data`={0x0200,0x0030}, `fwd_sel_a`=2, `fwd_sel_b`=1, `fwd_sel_c`=3 (out of range), `st_data`=0xBEEF → `alu_out`=0x0230 next cycle, `st_wdata_out`=0xBEEF.
- Shifts: a=0x8001, b=0x0011 → SLL 0x0002, SRL 0x4000, SRA 0xC000 (amount 1).
- MUL (macro on): a=0x0123, b=0x0045 → `in_ready`=0 for 16 cycles, then `alu_out`=0x4E6F; with macro off → `alu_out`=0x0000 after 1 cycle.
- Back-pressure: two back-to-back ADDs with `out_ready`=0 for 3 cycles → first result held stable, `in_ready`=0, second accepted the cycle `out_ready` rises, results in order.
- Reset mid-MUL at cycle 5 → `out_valid` stays 0; a following ADD 2+3 returns 0x0005 one cycle after acceptance.
